// File: rtl/amb_islenen_hazirla.sv
// Execute-stage operand preparation for the Toprak AMB: forwarding, PC/immediate
// operand selection and a 2-entry skid buffer with valid/ready on both sides.

package amb_islenen_hazirla_pkg;
  // Decoded ALU control word carried to the AMB unchanged.
  typedef struct packed {
    logic [3:0] islem;     // operation select
    logic       isaretli;  // signed compare / arithmetic shift
    logic       ters;      // subtract / invert operand 2
  } amb_kontrol_t;
endpackage

module amb_islenen_hazirla
  import amb_islenen_hazirla_pkg::*;
#(
  parameter int VERI_G = 32,
  parameter int ADR_G  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              temizle_i,
  input  logic              giris_gecerli_i,
  output logic              giris_hazir_o,
  input  amb_kontrol_t      giris_kontrol_i,
  input  logic [ADR_G-1:0]  giris_rs1_adr_i,
  input  logic [ADR_G-1:0]  giris_rs2_adr_i,
  input  logic [VERI_G-1:0] giris_rs1_veri_i,
  input  logic [VERI_G-1:0] giris_rs2_veri_i,
  input  logic [VERI_G-1:0] giris_anlik_i,
  input  logic [VERI_G-1:0] giris_pc_i,
  input  logic              giris_isl1_sec_i,
  input  logic              giris_isl2_sec_i,
  input  logic [ADR_G-1:0]  giris_rd_adr_i,
  input  logic              ileri_amb_gecerli_i,
  input  logic [ADR_G-1:0]  ileri_amb_rd_i,
  input  logic [VERI_G-1:0] ileri_amb_veri_i,
  input  logic              ileri_gy_gecerli_i,
  input  logic [ADR_G-1:0]  ileri_gy_rd_i,
  input  logic [VERI_G-1:0] ileri_gy_veri_i,
  output logic              cikis_gecerli_o,
  input  logic              cikis_hazir_i,
  output amb_kontrol_t      cikis_kontrol_o,
  output logic [VERI_G-1:0] cikis_yazmac1_o,
  output logic [VERI_G-1:0] cikis_yazmac2_o,
  output logic [ADR_G-1:0]  cikis_rd_o
);

  typedef enum logic [1:0] {BOS = 2'd0, DOLU1 = 2'd1, DOLU2 = 2'd2} durum_t;

  durum_t r_durum, w_durum_sonraki;

  amb_kontrol_t      r_ana_kontrol, r_skid_kontrol;
  logic [VERI_G-1:0] r_ana_y1, r_ana_y2, r_skid_y1, r_skid_y2;
  logic [ADR_G-1:0]  r_ana_rd, r_skid_rd;

  logic              w_al, w_ver;
  logic              w_ana_yeni, w_ana_skid, w_skid_yukle;
  logic [VERI_G-1:0] w_rs1, w_rs2, w_y1, w_y2;

  // Forward one source operand: AMB stage beats writeback beats the register file; x0 is always 0.
  function automatic logic [VERI_G-1:0] f_ilet(input logic [ADR_G-1:0]  adr,
                                                input logic [VERI_G-1:0] rf);
    if (adr == '0)                                      return '0;
    else if (ileri_amb_gecerli_i && ileri_amb_rd_i == adr) return ileri_amb_veri_i;
    else if (ileri_gy_gecerli_i && ileri_gy_rd_i == adr)   return ileri_gy_veri_i;
    else                                                return rf;
  endfunction

  assign giris_hazir_o   = (r_durum != DOLU2);
  assign cikis_gecerli_o = (r_durum != BOS);

  // An offer during a flush is dropped, so it never counts as accepted.
  assign w_al  = giris_gecerli_i & giris_hazir_o & ~temizle_i;
  assign w_ver = cikis_gecerli_o & cikis_hazir_i;

  // Operand resolution happens only here; captured data is never re-forwarded.
  always_comb begin
    w_rs1 = f_ilet(giris_rs1_adr_i, giris_rs1_veri_i);
    w_rs2 = f_ilet(giris_rs2_adr_i, giris_rs2_veri_i);
    w_y1  = giris_isl1_sec_i ? giris_pc_i    : w_rs1;
    w_y2  = giris_isl2_sec_i ? giris_anlik_i : w_rs2;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_durum <= BOS;
    else       r_durum <= w_durum_sonraki;
  end

  // Next state and storage load enables; flush overrides everything.
  always_comb begin
    w_durum_sonraki = r_durum;
    w_ana_yeni      = 1'b0;
    w_ana_skid      = 1'b0;
    w_skid_yukle    = 1'b0;
    if (temizle_i) begin
      w_durum_sonraki = BOS;
    end else begin
      case (r_durum)
        BOS: if (w_al) begin
          w_durum_sonraki = DOLU1;
          w_ana_yeni      = 1'b1;
        end
        DOLU1: begin
          if (w_al && w_ver) begin
            w_ana_yeni = 1'b1;
          end else if (w_ver) begin
            w_durum_sonraki = BOS;
          end else if (w_al) begin
            w_durum_sonraki = DOLU2;
            w_skid_yukle    = 1'b1;
          end
        end
        DOLU2: if (w_ver) begin
          w_durum_sonraki = DOLU1;
          w_ana_skid      = 1'b1;
        end
        default: w_durum_sonraki = BOS;
      endcase
    end
  end

  // Main entry: loaded from the input or promoted from the skid entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ana_kontrol <= '0;
      r_ana_y1      <= '0;
      r_ana_y2      <= '0;
      r_ana_rd      <= '0;
    end else if (w_ana_yeni) begin
      r_ana_kontrol <= giris_kontrol_i;
      r_ana_y1      <= w_y1;
      r_ana_y2      <= w_y2;
      r_ana_rd      <= giris_rd_adr_i;
    end else if (w_ana_skid) begin
      r_ana_kontrol <= r_skid_kontrol;
      r_ana_y1      <= r_skid_y1;
      r_ana_y2      <= r_skid_y2;
      r_ana_rd      <= r_skid_rd;
    end
  end

  // Skid entry: catches the one op accepted after the AMB stage stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_skid_kontrol <= '0;
      r_skid_y1      <= '0;
      r_skid_y2      <= '0;
      r_skid_rd      <= '0;
    end else if (w_skid_yukle) begin
      r_skid_kontrol <= giris_kontrol_i;
      r_skid_y1      <= w_y1;
      r_skid_y2      <= w_y2;
      r_skid_rd      <= giris_rd_adr_i;
    end
  end

  assign cikis_kontrol_o = r_ana_kontrol;
  assign cikis_yazmac1_o = r_ana_y1;
  assign cikis_yazmac2_o = r_ana_y2;
  assign cikis_rd_o      = r_ana_rd;

endmodule

// File: tb/tb_amb_islenen_hazirla.sv
// Bench for amb_islenen_hazirla: vector table for forwarding/operand select,
// scoreboard queue for ordering, hand sequences for backpressure, flush and reset.

module tb_amb_islenen_hazirla;
  import amb_islenen_hazirla_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         temizle = 1'b0;
  logic         g_gecerli = 1'b0;
  logic         g_hazir;
  amb_kontrol_t g_kontrol = '0;
  logic [4:0]   g_rs1_adr = '0, g_rs2_adr = '0, g_rd = '0;
  logic [31:0]  g_rs1 = '0, g_rs2 = '0, g_anlik = '0, g_pc = '0;
  logic         g_sec1 = 1'b0, g_sec2 = 1'b0;
  logic         a_g = 1'b0, w_g = 1'b0;
  logic [4:0]   a_rd = '0, w_rd = '0;
  logic [31:0]  a_veri = '0, w_veri = '0;
  logic         c_gecerli;
  logic         c_hazir = 1'b1;
  amb_kontrol_t c_kontrol;
  logic [31:0]  c_y1, c_y2;
  logic [4:0]   c_rd;

  amb_islenen_hazirla dut (
    .clk_i(clk), .rst_i(rst), .temizle_i(temizle),
    .giris_gecerli_i(g_gecerli), .giris_hazir_o(g_hazir),
    .giris_kontrol_i(g_kontrol),
    .giris_rs1_adr_i(g_rs1_adr), .giris_rs2_adr_i(g_rs2_adr),
    .giris_rs1_veri_i(g_rs1), .giris_rs2_veri_i(g_rs2),
    .giris_anlik_i(g_anlik), .giris_pc_i(g_pc),
    .giris_isl1_sec_i(g_sec1), .giris_isl2_sec_i(g_sec2),
    .giris_rd_adr_i(g_rd),
    .ileri_amb_gecerli_i(a_g), .ileri_amb_rd_i(a_rd), .ileri_amb_veri_i(a_veri),
    .ileri_gy_gecerli_i(w_g), .ileri_gy_rd_i(w_rd), .ileri_gy_veri_i(w_veri),
    .cikis_gecerli_o(c_gecerli), .cikis_hazir_i(c_hazir),
    .cikis_kontrol_o(c_kontrol),
    .cikis_yazmac1_o(c_y1), .cikis_yazmac2_o(c_y2), .cikis_rd_o(c_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  kontrol;
    logic [4:0]  rs1_adr, rs2_adr, rd;
    logic [31:0] rs1, rs2, anlik, pc;
    logic        sec1, sec2;
    logic        ag; logic [4:0] ard; logic [31:0] averi;
    logic        wg; logic [4:0] wrd; logic [31:0] wveri;
    logic [31:0] exp1, exp2;
  } vec_t;

  typedef struct {
    logic [5:0]  kontrol;
    logic [31:0] y1, y2;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0, n_cikis = 0;
  vec_t tbl[8];
  vec_t cur;

  task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", ad, act, req);
    end
  endtask

  // Scoreboard: an output transfer happens at the next edge whenever valid & ready.
  always @(negedge clk) begin
    if (!rst && c_gecerli && c_hazir) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: got y1=%0h y2=%0h rd=%0d, none expected", c_y1, c_y2, c_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_cikis++;
        if (c_kontrol !== e.kontrol || c_y1 !== e.y1 || c_y2 !== e.y2 || c_rd !== e.rd) begin
          failures++;
          $display("FAIL output_entry: got k=%0h y1=%0h y2=%0h rd=%0d expected k=%0h y1=%0h y2=%0h rd=%0d",
                   c_kontrol, c_y1, c_y2, c_rd, e.kontrol, e.y1, e.y2, e.rd);
        end
      end
    end
  end

  task automatic sur(input vec_t v);
    cur       = v;
    g_gecerli = 1'b1;
    g_kontrol = v.kontrol;
    g_rs1_adr = v.rs1_adr; g_rs2_adr = v.rs2_adr; g_rd = v.rd;
    g_rs1 = v.rs1; g_rs2 = v.rs2; g_anlik = v.anlik; g_pc = v.pc;
    g_sec1 = v.sec1; g_sec2 = v.sec2;
    a_g = v.ag; a_rd = v.ard; a_veri = v.averi;
    w_g = v.wg; w_rd = v.wrd; w_veri = v.wveri;
  endtask

  task automatic bos();
    g_gecerli = 1'b0; a_g = 1'b0; w_g = 1'b0;
  endtask

  // One cycle; the offered op is recorded as expected only if it will be accepted.
  task automatic kenar();
    @(negedge clk);
    if (g_gecerli && g_hazir && !temizle) begin
      exp_t e;
      e.kontrol = cur.kontrol; e.y1 = cur.exp1; e.y2 = cur.exp2; e.rd = cur.rd;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t duz(input logic [5:0] k, input logic [4:0] rd,
                               input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    v = '{kontrol: k, rs1_adr: 5'd1, rs2_adr: 5'd2, rd: rd, rs1: x, rs2: y,
          anlik: 32'h0, pc: 32'h0, sec1: 1'b0, sec2: 1'b0,
          ag: 1'b0, ard: 5'd0, averi: 32'h0, wg: 1'b0, wrd: 5'd0, wveri: 32'h0,
          exp1: x, exp2: y};
    return v;
  endfunction

  initial begin
    int base;
    // Forwarding / operand-select table (expected values taken from the block's rules)
    tbl[0] = duz(6'h01, 5'd3, 32'd5, 32'd7);
    tbl[1] = '{6'h02, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0,
               1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hAA, 32'h22};
    tbl[2] = '{6'h03, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0,
               1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'hBB, 32'h22};
    tbl[3] = '{6'h04, 5'd0, 5'd0, 5'd7, 32'h99, 32'h98, 32'h0, 32'h0, 1'b0, 1'b0,
               1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h56, 32'h0, 32'h0};
    tbl[4] = '{6'h05, 5'd3, 5'd3, 5'd8, 32'h11, 32'h11, 32'hFFFFFFFC, 32'h1000, 1'b1, 1'b1,
               1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB, 32'h00001000, 32'hFFFFFFFC};
    tbl[5] = '{6'h06, 5'd1, 5'd6, 5'd9, 32'h10, 32'h60, 32'h0, 32'h0, 1'b0, 1'b0,
               1'b1, 5'd7, 32'hA7, 1'b1, 5'd6, 32'h66, 32'h10, 32'h66};
    tbl[6] = '{6'h07, 5'd1, 5'd9, 5'd10, 32'h10, 32'h90, 32'h0, 32'h0, 1'b0, 1'b0,
               1'b1, 5'd9, 32'hA9, 1'b1, 5'd9, 32'hB9, 32'h10, 32'hA9};
    tbl[7] = '{6'h08, 5'd12, 5'd2, 5'd11, 32'h120, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0,
               1'b0, 5'd12, 32'hAC, 1'b0, 5'd12, 32'hBC, 32'h120, 32'h20};

    // Reset with no clock edge in between
    #1 rst = 1'b1;
    #1;
    chk("rst_gecerli", c_gecerli, 0);
    chk("rst_hazir",   g_hazir,   1);
    chk("rst_kontrol", c_kontrol, 0);
    chk("rst_y1",      c_y1,      0);
    chk("rst_y2",      c_y2,      0);
    chk("rst_rd",      c_rd,      0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors, back to back
    for (int i = 0; i < 8; i++) begin
      sur(tbl[i]);
      kenar();
    end
    bos(); kenar(); kenar();
    chk("table_all_out", n_cikis, 8);

    // 8-op stream: one output every cycle
    base = n_cikis;
    for (int i = 0; i < 8; i++) begin
      sur(duz(6'(i), 5'(i + 1), $urandom, $urandom));
      kenar();
      chk("stream_hazir",   g_hazir,   1);
      chk("stream_gecerli", c_gecerli, 1);
    end
    bos(); kenar();
    chk("stream_count", n_cikis - base, 8);
    chk("stream_bos",   c_gecerli, 0);

    // Backpressure: A in main, B in skid, C held off
    base = n_cikis;
    c_hazir = 1'b0;
    sur(duz(6'h0A, 5'd20, 32'hA1, 32'hA2)); kenar();
    sur(duz(6'h0B, 5'd21, 32'hB1, 32'hB2)); kenar();
    chk("bp_hazir_low", g_hazir,   0);
    chk("bp_gecerli",   c_gecerli, 1);
    chk("bp_main_A",    c_y1,      32'hA1);
    sur(duz(6'h0C, 5'd22, 32'hC1, 32'hC2)); kenar(); kenar();
    chk("bp_hold_hazir", g_hazir, 0);
    chk("bp_hold_A",     c_y2,    32'hA2);
    c_hazir = 1'b1;
    kenar(); kenar();
    bos(); kenar(); kenar();
    chk("bp_count",  n_cikis - base, 3);
    chk("bp_q_bos",  q.size(), 0);

    // Flush while full: both held entries and the offered op are dropped
    c_hazir = 1'b0;
    sur(duz(6'h0D, 5'd23, 32'hD1, 32'hD2)); kenar();
    sur(duz(6'h0E, 5'd24, 32'hE1, 32'hE2)); kenar();
    chk("fl_dolu2", g_hazir, 0);
    sur(duz(6'h0F, 5'd25, 32'hF1, 32'hF2));
    temizle = 1'b1;
    kenar();
    temizle = 1'b0; bos();
    chk("fl_gecerli", c_gecerli, 0);
    chk("fl_hazir",   g_hazir,   1);
    q.delete();
    c_hazir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      kenar();
      chk("fl_no_reappear", c_gecerli, 0);
    end

    // Flush together with consume: the consumed entry still transfers
    base = n_cikis;
    sur(duz(6'h10, 5'd26, 32'h51, 32'h52)); kenar();
    bos(); temizle = 1'b1; kenar(); temizle = 1'b0;
    chk("flc_count",   n_cikis - base, 1);
    chk("flc_gecerli", c_gecerli, 0);

    // Async reset mid-cycle while full
    c_hazir = 1'b0;
    sur(duz(6'h11, 5'd27, 32'h61, 32'h62)); kenar();
    sur(duz(6'h12, 5'd28, 32'h71, 32'h72)); kenar();
    chk("rr_dolu2", g_hazir, 0);
    bos();
    #2 rst = 1'b1;
    #1;
    chk("rr_gecerli", c_gecerli, 0);
    chk("rr_hazir",   g_hazir,   1);
    chk("rr_y1",      c_y1,      0);
    chk("rr_rd",      c_rd,      0);
    q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    c_hazir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      kenar();
      chk("rr_no_reappear", c_gecerli, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
